// File: rtl/chimera_wide_bypass_switch.sv
// Wide-path bypass-mode switch: drains outstanding wide AXI traffic before
// flipping the adapter bypass mode, and caps outstanding reads and writes.
module chimera_wide_bypass_switch #(
  parameter int unsigned MaxWrTxns    = 8,
  parameter int unsigned MaxRdTxns    = 8,
  parameter int unsigned SettleCycles = 4
) (
  input  logic                               soc_clk_i,
  input  logic                               rst_i,
  input  logic                               bypass_req_i,
  output logic                               bypass_o,
  output logic                               busy_o,
  input  logic                               aw_valid_i,
  output logic                               aw_ready_o,
  output logic                               aw_valid_o,
  input  logic                               aw_ready_i,
  input  logic                               ar_valid_i,
  output logic                               ar_ready_o,
  output logic                               ar_valid_o,
  input  logic                               ar_ready_i,
  input  logic                               b_valid_i,
  input  logic                               b_ready_i,
  input  logic                               r_valid_i,
  input  logic                               r_ready_i,
  input  logic                               r_last_i,
  output logic [$clog2(MaxWrTxns+1)-1:0]     wr_cnt_o,
  output logic [$clog2(MaxRdTxns+1)-1:0]     rd_cnt_o
);

  localparam int unsigned WrW  = $clog2(MaxWrTxns + 1);
  localparam int unsigned RdW  = $clog2(MaxRdTxns + 1);
  localparam int unsigned TmrW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
  localparam logic [WrW-1:0] WrMax = WrW'(MaxWrTxns);
  localparam logic [RdW-1:0] RdMax = RdW'(MaxRdTxns);

  typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            bypass_q, bypass_d;
  logic            aw_lock_q, aw_lock_d, ar_lock_q, ar_lock_d;
  logic [WrW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [RdW-1:0]  rd_cnt_q, rd_cnt_d;
  logic            wr_inc, wr_dec, rd_inc, rd_dec;
  logic            aw_lock_req, ar_lock_req;

  assign aw_valid_o = aw_valid_i & ~aw_lock_q;
  assign aw_ready_o = aw_ready_i & ~aw_lock_q;
  assign ar_valid_o = ar_valid_i & ~ar_lock_q;
  assign ar_ready_o = ar_ready_i & ~ar_lock_q;

  assign wr_inc = aw_valid_o & aw_ready_i;
  assign wr_dec = b_valid_i & b_ready_i;
  assign rd_inc = ar_valid_o & ar_ready_i;
  assign rd_dec = r_valid_i & r_ready_i & r_last_i;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_inc && !wr_dec)
      wr_cnt_d = wr_cnt_q + 1'b1;
    else if (!wr_inc && wr_dec && wr_cnt_q != '0)
      wr_cnt_d = wr_cnt_q - 1'b1;
    rd_cnt_d = rd_cnt_q;
    if (rd_inc && !rd_dec)
      rd_cnt_d = rd_cnt_q + 1'b1;
    else if (!rd_inc && rd_dec && rd_cnt_q != '0)
      rd_cnt_d = rd_cnt_q - 1'b1;
  end

  // Also request the lock when this cycle's handshake reaches Max, so the
  // registered lock closes on that same edge and the count cannot overshoot.
  assign aw_lock_req = (state_q != IDLE) || (wr_cnt_q == WrMax) || (wr_cnt_d == WrMax);
  assign ar_lock_req = (state_q != IDLE) || (rd_cnt_q == RdMax) || (rd_cnt_d == RdMax);

  // A lock may only close while valid is low or handshaking, never mid-offer.
  assign aw_lock_d = aw_lock_req & (aw_lock_q | ~aw_valid_i | aw_ready_i);
  assign ar_lock_d = ar_lock_req & (ar_lock_q | ~ar_valid_i | ar_ready_i);

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bypass_d = bypass_q;
    case (state_q)
      IDLE: begin
        if (bypass_req_i != bypass_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Request changes after leaving IDLE are ignored; the mode always flips.
        if (aw_lock_q && ar_lock_q && wr_cnt_q == '0 && rd_cnt_q == '0) begin
          state_d  = SWITCH;
          bypass_d = ~bypass_q;
        end
      end
      SWITCH: begin
        if (SettleCycles == 0) begin
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
          tmr_d   = TmrW'(SettleCycles);
        end
      end
      SETTLE: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      bypass_q  <= 1'b0;
      aw_lock_q <= 1'b0;
      ar_lock_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bypass_q  <= bypass_d;
      aw_lock_q <= aw_lock_d;
      ar_lock_q <= ar_lock_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign bypass_o = bypass_q;
  assign busy_o   = (state_q != IDLE);
  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;

  wr_underflow_a: assert property (@(posedge soc_clk_i) disable iff (rst_i)
    !(wr_dec && !wr_inc && wr_cnt_q == '0))
    else $warning("wide B handshake with no outstanding write");

  rd_underflow_a: assert property (@(posedge soc_clk_i) disable iff (rst_i)
    !(rd_dec && !rd_inc && rd_cnt_q == '0))
    else $warning("wide R last handshake with no outstanding read");

  cnt_cap_a: assert property (@(posedge soc_clk_i) disable iff (rst_i)
    (wr_cnt_q <= WrMax) && (rd_cnt_q <= RdMax))
    else $error("outstanding wide transaction count above cap");

endmodule

// File: tb/tb_chimera_wide_bypass_switch.sv
// Bench for chimera_wide_bypass_switch: directed scenarios plus randomized
// AXI traffic checked against a transaction-level outstanding-count model.
module tb_chimera_wide_bypass_switch;

  localparam int unsigned MaxWr  = 8;
  localparam int unsigned MaxRd  = 8;
  localparam int unsigned Settle = 4;

  logic clk = 1'b0;
  logic rst, bypass_req, bypass_o, busy_o;
  logic aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
  logic b_valid, b_ready, r_valid, r_ready, r_last;
  logic [$clog2(MaxWr+1)-1:0] wr_cnt;
  logic [$clog2(MaxRd+1)-1:0] rd_cnt;

  int tests = 0;
  int fails = 0;

  chimera_wide_bypass_switch #(
    .MaxWrTxns(MaxWr), .MaxRdTxns(MaxRd), .SettleCycles(Settle)
  ) dut (
    .soc_clk_i(clk), .rst_i(rst), .bypass_req_i(bypass_req),
    .bypass_o(bypass_o), .busy_o(busy_o),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aw_valid_i = 0; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 0;
    b_valid = 0; b_ready = 0; r_valid = 0; r_ready = 0; r_last = 0;
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < 40) begin tick(); n++; end
    tick();
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL %s_idle: busy_o got %b expected 0", name, busy_o); end
  endtask

  task automatic test_reset();
    rst = 1; bypass_req = 0; idle_inputs();
    tick(); tick();
    rst = 0;
    tests++; if (bypass_o !== 1'b0) begin fails++; $display("FAIL reset_bypass: got %b expected 0", bypass_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    tests++; if (wr_cnt !== 0) begin fails++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
    tests++; if (rd_cnt !== 0) begin fails++; $display("FAIL reset_rd_cnt: got %0d expected 0", rd_cnt); end
    aw_valid_i = 1; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 1;
    #1;
    tests++; if ({aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o} !== 4'b1001) begin
      fails++; $display("FAIL reset_passthru: got %b expected 1001", {aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o});
    end
    idle_inputs();
  endtask

  // Idle buses: mode visible 3 edges after the request, busy for
  // 2 (lock) + 1 (switch) + Settle + 1 cycles, channels reopen one edge later.
  task automatic test_idle_switch();
    logic exp_byp, exp_busy, exp_lock;
    aw_ready_i = 1; ar_ready_i = 1; bypass_req = 1;
    for (int k = 1; k <= int'(Settle) + 7; k++) begin
      tick();
      exp_byp  = (k >= 3);
      exp_busy = (k <= int'(Settle) + 4);
      exp_lock = (k >= 2) && (k <= int'(Settle) + 5);
      tests++; if (bypass_o !== exp_byp) begin fails++; $display("FAIL idle_bypass k=%0d: got %b expected %b", k, bypass_o, exp_byp); end
      tests++; if (busy_o !== exp_busy) begin fails++; $display("FAIL idle_busy k=%0d: got %b expected %b", k, busy_o, exp_busy); end
      tests++; if ({aw_ready_o, ar_ready_o} !== {2{~exp_lock}}) begin
        fails++; $display("FAIL idle_ready k=%0d: got %b expected %b", k, {aw_ready_o, ar_ready_o}, {2{~exp_lock}});
      end
    end
    idle_inputs();
  endtask

  task automatic test_drain_writes();
    aw_valid_i = 1; aw_ready_i = 1;
    repeat (3) tick();
    idle_inputs();
    tests++; if (wr_cnt !== 3) begin fails++; $display("FAIL drain_wr_start: got %0d expected 3", wr_cnt); end
    bypass_req = 0;
    for (int i = 0; i < 3; i++) begin
      repeat (4) begin
        tick();
        tests++; if (bypass_o !== 1'b1) begin fails++; $display("FAIL drain_hold_bypass: got %b expected 1", bypass_o); end
        tests++; if (wr_cnt !== 3 - i) begin fails++; $display("FAIL drain_hold_cnt: got %0d expected %0d", wr_cnt, 3 - i); end
      end
      b_valid = 1; b_ready = 1;
      tick();
      b_valid = 0; b_ready = 0;
      tests++; if (wr_cnt !== 2 - i) begin fails++; $display("FAIL drain_b_cnt: got %0d expected %0d", wr_cnt, 2 - i); end
      tests++; if (bypass_o !== 1'b1) begin fails++; $display("FAIL drain_b_bypass: got %b expected 1", bypass_o); end
    end
    tick();
    tests++; if (bypass_o !== 1'b0) begin fails++; $display("FAIL drain_flip: got %b expected 0", bypass_o); end
    wait_not_busy("drain");
  endtask

  task automatic test_reset_settle();
    bypass_req = 1;
    repeat (5) tick();
    tests++; if ({busy_o, bypass_o} !== 2'b11) begin fails++; $display("FAIL rstset_pre: got %b expected 11", {busy_o, bypass_o}); end
    rst = 1; bypass_req = 0;
    tick();
    rst = 0;
    tests++; if ({bypass_o, busy_o} !== 2'b00) begin fails++; $display("FAIL rstset_state: got %b expected 00", {bypass_o, busy_o}); end
    tests++; if (wr_cnt !== 0 || rd_cnt !== 0) begin fails++; $display("FAIL rstset_cnt: got %0d/%0d expected 0/0", wr_cnt, rd_cnt); end
    aw_valid_i = 1; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 1;
    #1;
    tests++; if ({aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o} !== 4'b1001) begin
      fails++; $display("FAIL rstset_passthru: got %b expected 1001", {aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o});
    end
    idle_inputs();
  endtask

  task automatic test_hold_valid();
    aw_valid_i = 1; aw_ready_i = 0; bypass_req = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++; if (aw_valid_o !== 1'b1) begin fails++; $display("FAIL hold_valid k=%0d: got %b expected 1", k, aw_valid_o); end
      tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL hold_busy k=%0d: got %b expected 1", k, busy_o); end
    end
    aw_ready_i = 1;
    #1;
    tests++; if (aw_ready_o !== 1'b1) begin fails++; $display("FAIL hold_ready_open: got %b expected 1", aw_ready_o); end
    tick();
    tests++; if (wr_cnt !== 1) begin fails++; $display("FAIL hold_cnt: got %0d expected 1", wr_cnt); end
    tests++; if ({aw_valid_o, aw_ready_o} !== 2'b00) begin fails++; $display("FAIL hold_locked: got %b expected 00", {aw_valid_o, aw_ready_o}); end
    idle_inputs();
    repeat (3) begin
      tick();
      tests++; if (bypass_o !== 1'b0 || wr_cnt !== 1) begin fails++; $display("FAIL hold_drain: got bypass %b cnt %0d expected 0/1", bypass_o, wr_cnt); end
    end
    b_valid = 1; b_ready = 1;
    tick();
    b_valid = 0; b_ready = 0;
    tests++; if (wr_cnt !== 0) begin fails++; $display("FAIL hold_b_cnt: got %0d expected 0", wr_cnt); end
    tick();
    tests++; if (bypass_o !== 1'b1) begin fails++; $display("FAIL hold_flip: got %b expected 1", bypass_o); end
    wait_not_busy("hold");
  endtask

  task automatic test_rd_cap();
    ar_valid_i = 1; ar_ready_i = 1;
    for (int i = 0; i < int'(MaxRd); i++) begin
      tick();
      tests++; if (rd_cnt !== i + 1) begin fails++; $display("FAIL cap_fill: got %0d expected %0d", rd_cnt, i + 1); end
    end
    tests++; if ({ar_valid_o, ar_ready_o} !== 2'b00) begin fails++; $display("FAIL cap_locked: got %b expected 00", {ar_valid_o, ar_ready_o}); end
    repeat (2) tick();
    tests++; if (rd_cnt !== MaxRd || ar_ready_o !== 1'b0) begin fails++; $display("FAIL cap_hold: got cnt %0d ready %b expected %0d/0", rd_cnt, ar_ready_o, MaxRd); end
    r_valid = 1; r_ready = 1; r_last = 1;
    tick();
    r_valid = 0; r_ready = 0; r_last = 0; ar_valid_i = 0;
    tests++; if (rd_cnt !== MaxRd - 1) begin fails++; $display("FAIL cap_rlast: got %0d expected %0d", rd_cnt, MaxRd - 1); end
    tests++; if (ar_ready_o !== 1'b0) begin fails++; $display("FAIL cap_still_locked: got %b expected 0", ar_ready_o); end
    tick();
    tests++; if (ar_ready_o !== 1'b1) begin fails++; $display("FAIL cap_reopen: got %b expected 1", ar_ready_o); end
    tests++; if (rd_cnt !== MaxRd - 1) begin fails++; $display("FAIL cap_reopen_cnt: got %0d expected %0d", rd_cnt, MaxRd - 1); end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    r_valid = 1; r_ready = 1; r_last = 1;
    repeat (2) tick();
    tests++; if (rd_cnt !== 5) begin fails++; $display("FAIL same_pre: got %0d expected 5", rd_cnt); end
    ar_valid_i = 1; ar_ready_i = 1;
    tick();
    idle_inputs();
    tests++; if (rd_cnt !== 5) begin fails++; $display("FAIL same_cycle_rd: got %0d expected 5", rd_cnt); end
    b_valid = 1; b_ready = 1;
    tick();
    idle_inputs();
    tests++; if (wr_cnt !== 0) begin fails++; $display("FAIL underflow_wr: got %0d expected 0", wr_cnt); end
    r_valid = 1; r_ready = 1; r_last = 1;
    repeat (5) tick();
    idle_inputs();
    tests++; if (rd_cnt !== 0) begin fails++; $display("FAIL same_cleanup: got %0d expected 0", rd_cnt); end
  endtask

  // Counts come from accepted handshakes at the adapter boundary minus
  // responses; mode flips must only occur with nothing outstanding.
  task automatic test_random();
    int   wr_m = 0, rd_m = 0, wr_before, rd_before;
    logic aw_hs, ar_hs, b_hs, r_hs, aw_acc, ar_acc, prev_byp, prev_busy;
    logic aw_pend = 0, ar_pend = 0, aw_stall = 0, ar_stall = 0;
    bit   draining, finished = 0;
    idle_inputs();
    for (int cyc = 0; cyc < 700 && !finished; cyc++) begin
      draining = (cyc >= 400);
      if (!aw_stall) aw_valid_i = !draining && ($urandom_range(0, 2) == 0);
      if (!ar_stall) ar_valid_i = !draining && ($urandom_range(0, 2) == 0);
      aw_ready_i = draining || ($urandom_range(0, 1) == 1);
      ar_ready_i = draining || ($urandom_range(0, 1) == 1);
      b_valid = (wr_m > 0) && (draining || $urandom_range(0, 2) == 0);
      b_ready = draining || ($urandom_range(0, 1) == 1);
      r_valid = (rd_m > 0) && (draining || $urandom_range(0, 2) == 0);
      r_ready = draining || ($urandom_range(0, 1) == 1);
      r_last  = draining || ($urandom_range(0, 1) == 1);
      if (!draining && $urandom_range(0, 39) == 0) bypass_req = ~bypass_req;
      #1;
      if (aw_pend) begin tests++; if (aw_valid_o !== 1'b1) begin fails++; $display("FAIL rand_aw_hold cyc=%0d: got %b expected 1", cyc, aw_valid_o); end end
      if (ar_pend) begin tests++; if (ar_valid_o !== 1'b1) begin fails++; $display("FAIL rand_ar_hold cyc=%0d: got %b expected 1", cyc, ar_valid_o); end end
      tests++;
      if (({aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o} & ~{aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i}) !== 4'b0000) begin
        fails++; $display("FAIL rand_gate_leak cyc=%0d: got out %b in %b", cyc,
          {aw_valid_o, aw_ready_o, ar_valid_o, ar_ready_o}, {aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i});
      end
      if (aw_valid_i && aw_ready_i) begin tests++; if (aw_valid_o !== aw_ready_o) begin fails++; $display("FAIL rand_aw_gate cyc=%0d: got %b%b expected equal", cyc, aw_valid_o, aw_ready_o); end end
      aw_hs = aw_valid_o & aw_ready_i;  ar_hs = ar_valid_o & ar_ready_i;
      aw_acc = aw_valid_i & aw_ready_o; ar_acc = ar_valid_i & ar_ready_o;
      b_hs = b_valid & b_ready;         r_hs = r_valid & r_ready & r_last;
      aw_pend = aw_valid_o & ~aw_ready_i; ar_pend = ar_valid_o & ~ar_ready_i;
      prev_byp = bypass_o; prev_busy = busy_o; wr_before = wr_m; rd_before = rd_m;
      tick();
      wr_m = wr_m + int'(aw_hs) - int'(b_hs);
      rd_m = rd_m + int'(ar_hs) - int'(r_hs);
      aw_stall = aw_valid_i & ~aw_acc;
      ar_stall = ar_valid_i & ~ar_acc;
      tests++; if (int'(wr_cnt) != wr_m) begin fails++; $display("FAIL rand_wr_cnt cyc=%0d: got %0d expected %0d", cyc, wr_cnt, wr_m); end
      tests++; if (int'(rd_cnt) != rd_m) begin fails++; $display("FAIL rand_rd_cnt cyc=%0d: got %0d expected %0d", cyc, rd_cnt, rd_m); end
      tests++; if (wr_m > int'(MaxWr) || rd_m > int'(MaxRd)) begin fails++; $display("FAIL rand_cap cyc=%0d: got %0d/%0d expected <=%0d/%0d", cyc, wr_m, rd_m, MaxWr, MaxRd); end
      if (bypass_o !== prev_byp) begin
        tests++;
        if (!(prev_busy === 1'b1 && wr_before == 0 && rd_before == 0)) begin
          fails++; $display("FAIL rand_unsafe_flip cyc=%0d: got busy %b wr %0d rd %0d expected 1/0/0", cyc, prev_busy, wr_before, rd_before);
        end
      end
      if (draining && wr_m == 0 && rd_m == 0 && !aw_stall && !ar_stall && busy_o === 1'b0 && bypass_o === bypass_req)
        finished = 1;
    end
    tests++; if (!finished) begin fails++; $display("FAIL rand_drain_timeout: got busy %b bypass %b expected 0/%b", busy_o, bypass_o, bypass_req); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_idle_switch();
    test_drain_writes();
    test_reset_settle();
    test_hold_valid();
    test_rd_cap();
    test_same_cycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
